motor_update_ctrl: RTL and testbench
====================================

// Module: motor_update_ctrl
// PURPOSE
//  Sequences the quad-X motor mixer between the rate-PID stage and the PWM/ESC encoders.
//  - Accepts axis commands through a valid/ready handshake and pre-limits them so the mixer sums cannot overflow.
//  - Samples the mixer outputs once per PWM frame tick, then clamps them.
//  - Owns the arm/disarm/failsafe state machine that gates what reaches the motors.
// PARAMETERS
//  THR_LIM    8191   throttle input clamp, range [0,THR_LIM]
//  AXIS_LIM   8191   pitch/roll/yaw input clamp, range [-AXIS_LIM,+AXIS_LIM]
//  MOTOR_IDLE 1200   armed minimum motor command (spin floor)
//  MOTOR_MAX  16000  maximum motor command
//  RAMP_STEP  100    per-tick increment during the ARMING spin-up ramp
//  ARM_THR    200    arm_req is honoured only if held throttle <= ARM_THR
//  STALE_MAX  8      consecutive ticks with no new command before failsafe
//  SLEW_MAX   400    max per-tick motor change (SLEW_LIMIT_EN only)
// PORTS
//  clk          in   1     system clock
//  rst          in   1     asynchronous, active-high reset
//  cmd_valid    in   1     command valid
//  cmd_ready    out  1     = !hold_full
//  cmd_thr      in   s16   throttle command
//  cmd_pitch    in   s16   pitch command
//  cmd_roll     in   s16   roll command
//  cmd_yaw      in   s16   yaw command
//  update_tick  in   1     1-cycle PWM frame strobe
//  arm_req      in   1     arm request (level or pulse)
//  disarm_req   in   1     disarm request (level or pulse)
//  failsafe_in  in   1     external failsafe (RC loss, etc.)
//  mix_thr/pitch/roll/yaw  out  s16 x4  to mixer, clamped hold-register values
//  mix_m1..mix_m4          in   s16 x4  from mixer (combinational)
//  motor_cmd1..4           out  s16 x4  to PWM encoders
//  motor_valid  out  1     1-cycle pulse when motor_cmd* update
//  state_o      out  2     0=DISARMED 1=ARMING 2=ARMED 3=FAILSAFE
// BEHAVIOUR
//  Reset values
//  - state DISARMED; motor_cmd* = 0; motor_valid = 0; hold empty; stale_cnt = 0; mix_* = 0.
//  - Reset takes effect mid-ramp or mid-pipeline, discarding in-flight data.
//  Input handshake
//  - Transfer occurs when cmd_valid && cmd_ready.
//  - Transfer stores the saturated fields in the 1-entry hold register and sets hold_full.
//  - Clamping is applied on capture, not on output:
//    - throttle to [0,THR_LIM]
//    - axes to [-AXIS_LIM,+AXIS_LIM]
//  - mix_* always drive the most recent captured values, kept after consumption.
//  Tick processing
//  - At update_tick, hold_full clears.
//  - A transfer in the same cycle as a tick is accepted; it belongs to the next tick.
//  - Hold empty at tick: stale_cnt++ and the last values are reused.
//  - Hold full at tick: stale_cnt = 0.
//  Pipeline (tick at cycle T)
//  - T+1: registered mix_m* are clamped to [MOTOR_IDLE,MOTOR_MAX].
//  - T+2: motor_cmd* update and motor_valid = 1 (fixed 2-cycle latency, every tick, all states).
//  FSM (priority per cycle: disarm_req > failsafe > arm_req)
//  - DISARMED:
//    - motor_cmd = 0.
//    - arm_req && last throttle <= ARM_THR -> ARMING with ramp = 0.
//    - arm_req with throttle above ARM_THR is ignored.
//  - ARMING:
//    - all motors = ramp; ramp += RAMP_STEP per tick, saturating at MOTOR_IDLE.
//    - When ramp reaches MOTOR_IDLE -> ARMED.
//  - ARMED: motor_cmd = clamped mixer outputs.
//  - Any state -> DISARMED on disarm_req: motors 0 on the next tick's output.
//  - ARMING/ARMED -> FAILSAFE on failsafe_in, or when stale_cnt reaches STALE_MAX.
//  - FAILSAFE:
//    - motor_cmd = 0.
//    - Exits only on disarm_req -> DISARMED.
//    - arm_req is ignored.
//  - stale_cnt saturates at STALE_MAX, so it cannot wrap.
//  - stale_cnt is cleared on entry to DISARMED.
// CONFIGURATION
//  Macro: MOTOR_UPDATE_CTRL_SLEW_LIMIT_EN
//  - Defined: in ARMED, each motor_cmd changes by at most SLEW_MAX per tick, from its previous value.
//    - DISARMED/FAILSAFE zeroing bypasses the limit.
//    - The ARMED entry value is MOTOR_IDLE.
//  - Undefined: clamped mixer values pass straight through; the SLEW_MAX parameter is unused.
// TESTING
//  - Reset, then tick -> motor_valid at T+2, motor_cmd* = 0, state 0.
//  - arm_req with thr = 100, 12 ticks -> ramp 100,200..1200, then state 2.
//  - arm_req with thr = 500 -> stays DISARMED.
//  - ARMED, cmd thr = 8000, pitch = 3000, others 0:
//    - m1 = m2 = 11000, m3 = m4 = 5000.
//    - With slew enabled, m1 steps 1600, 2000... from 1200.
//  - cmd thr = 30000, axes = 30000 -> clamped to 8191 each; m1 = 16382 -> motor_cmd1 = 16000; no wrap.
//  - ARMED, 8 ticks without a command -> FAILSAFE, motors 0.
//    - arm_req is then ignored; disarm_req -> DISARMED.
//  - Same cycle disarm_req + failsafe_in -> DISARMED.
//  - Transfer coinciding with a tick -> captured; cmd_ready low until the next tick.

Source files
------------

// File: rtl/motor_update_ctrl.sv
// Command hold/clamp stage, per-tick motor pipeline and arm/failsafe FSM for a quad-X mixer.
// Optional macro MOTOR_UPDATE_CTRL_SLEW_LIMIT_EN limits per-tick motor change while armed.
module motor_update_ctrl #(
  parameter int THR_LIM    = 8191,
  parameter int AXIS_LIM   = 8191,
  parameter int MOTOR_IDLE = 1200,
  parameter int MOTOR_MAX  = 16000,
  parameter int RAMP_STEP  = 100,
  parameter int ARM_THR    = 200,
  parameter int STALE_MAX  = 8,
  parameter int SLEW_MAX   = 400
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic signed [15:0] i_cmd_thr,
  input  logic signed [15:0] i_cmd_pitch,
  input  logic signed [15:0] i_cmd_roll,
  input  logic signed [15:0] i_cmd_yaw,
  input  logic               i_update_tick,
  input  logic               i_arm_req,
  input  logic               i_disarm_req,
  input  logic               i_failsafe_in,
  output logic signed [15:0] o_mix_thr,
  output logic signed [15:0] o_mix_pitch,
  output logic signed [15:0] o_mix_roll,
  output logic signed [15:0] o_mix_yaw,
  input  logic signed [15:0] i_mix_m1,
  input  logic signed [15:0] i_mix_m2,
  input  logic signed [15:0] i_mix_m3,
  input  logic signed [15:0] i_mix_m4,
  output logic signed [15:0] o_motor_cmd1,
  output logic signed [15:0] o_motor_cmd2,
  output logic signed [15:0] o_motor_cmd3,
  output logic signed [15:0] o_motor_cmd4,
  output logic               o_motor_valid,
  output logic [1:0]         o_state
);

  localparam int SW = $clog2(STALE_MAX + 1);
  localparam logic signed [15:0] LThrLim  = 16'(THR_LIM);
  localparam logic signed [15:0] LAxisLim = 16'(AXIS_LIM);
  localparam logic signed [15:0] LIdle    = 16'(MOTOR_IDLE);
  localparam logic signed [15:0] LMax     = 16'(MOTOR_MAX);
  localparam logic signed [15:0] LStep    = 16'(RAMP_STEP);
  localparam logic signed [15:0] LArmThr  = 16'(ARM_THR);
  localparam logic [SW-1:0]      LStale   = SW'(STALE_MAX);

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArming   = 2'd1,
    StArmed    = 2'd2,
    StFailsafe = 2'd3
  } state_e;

  typedef enum logic [1:0] {OutZero, OutRamp, OutMix} out_e;

  function automatic logic signed [15:0] sat(input logic signed [15:0] v,
                                             input logic signed [15:0] lo,
                                             input logic signed [15:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  state_e                r_state, w_state_d;
  out_e                  r_mode, w_mode_d;
  logic signed [15:0]    r_ramp, w_ramp_d, r_ramp_out;
  logic [SW-1:0]         r_stale, w_stale_d;
  logic                  r_hold_full, r_p1_valid, r_motor_valid;
  logic signed [15:0]    r_thr, r_pitch, r_roll, r_yaw;
  logic signed [15:0]    r_clamp [4];
  logic signed [15:0]    r_motor [4];
  logic signed [15:0]    w_mix_m [4];
  logic signed [15:0]    w_motor_d [4];
  logic signed [15:0]    w_target [4];
  logic                  w_xfer, w_stale_hit;

  assign w_xfer      = i_cmd_valid && !r_hold_full;
  assign o_cmd_ready = !r_hold_full;
  assign w_mix_m[0]  = i_mix_m1;
  assign w_mix_m[1]  = i_mix_m2;
  assign w_mix_m[2]  = i_mix_m3;
  assign w_mix_m[3]  = i_mix_m4;

  // Stale counter: a tick that finds the hold register empty counts as a missed command.
  always_comb begin
    w_stale_d = r_stale;
    if (i_update_tick) begin
      if (r_hold_full)           w_stale_d = '0;
      else if (r_stale < LStale) w_stale_d = r_stale + SW'(1);
    end
    if (i_disarm_req) w_stale_d = '0;
  end

  assign w_stale_hit = (w_stale_d == LStale);

  always_comb begin
    w_state_d = r_state;
    w_ramp_d  = r_ramp;
    w_mode_d  = OutZero;
    if (r_state == StArmed)  w_mode_d = OutMix;
    if (r_state == StArming) w_mode_d = OutRamp;
    if (i_update_tick && r_state == StArming) begin
      w_ramp_d = (r_ramp >= LIdle - LStep) ? LIdle : r_ramp + LStep;
    end
    unique case (r_state)
      StDisarmed: begin
        if (i_arm_req && !i_failsafe_in && r_thr <= LArmThr) begin
          w_state_d = StArming;
          w_ramp_d  = '0;
        end
      end
      StArming: begin
        if (i_failsafe_in || w_stale_hit) w_state_d = StFailsafe;
        else if (w_ramp_d == LIdle)       w_state_d = StArmed;
      end
      StArmed: begin
        if (i_failsafe_in || w_stale_hit) w_state_d = StFailsafe;
      end
      StFailsafe: ;
    endcase
    if (i_disarm_req) w_state_d = StDisarmed;
  end

`ifdef MOTOR_UPDATE_CTRL_SLEW_LIMIT_EN
  localparam logic signed [15:0] LSlew = 16'(SLEW_MAX);
  logic signed [15:0] w_diff [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      // Both operands lie in [0, MOTOR_MAX], so a 16-bit difference cannot overflow.
      w_diff[k] = r_clamp[k] - r_motor[k];
      if (w_diff[k] > LSlew)       w_target[k] = r_motor[k] + LSlew;
      else if (w_diff[k] < -LSlew) w_target[k] = r_motor[k] - LSlew;
      else                         w_target[k] = r_clamp[k];
    end
  end
`else
  logic w_unused_slew;
  assign w_unused_slew = ^16'(SLEW_MAX);

  always_comb begin
    for (int k = 0; k < 4; k++) w_target[k] = r_clamp[k];
  end
`endif

  // Zeroing follows the live state so a disarm/failsafe overrides an in-flight sample.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_motor_d[k] = '0;
      if (r_state == StArming || r_state == StArmed) begin
        if (r_mode == OutRamp)     w_motor_d[k] = r_ramp_out;
        else if (r_mode == OutMix) w_motor_d[k] = w_target[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StDisarmed;
      r_mode        <= OutZero;
      r_ramp        <= '0;
      r_ramp_out    <= '0;
      r_stale       <= '0;
      r_hold_full   <= 1'b0;
      r_thr         <= '0;
      r_pitch       <= '0;
      r_roll        <= '0;
      r_yaw         <= '0;
      r_p1_valid    <= 1'b0;
      r_motor_valid <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_clamp[k] <= '0;
        r_motor[k] <= '0;
      end
    end else begin
      r_state     <= w_state_d;
      r_ramp      <= w_ramp_d;
      r_stale     <= w_stale_d;
      r_hold_full <= w_xfer || (r_hold_full && !i_update_tick);
      if (w_xfer) begin
        r_thr   <= sat(i_cmd_thr, '0, LThrLim);
        r_pitch <= sat(i_cmd_pitch, -LAxisLim, LAxisLim);
        r_roll  <= sat(i_cmd_roll, -LAxisLim, LAxisLim);
        r_yaw   <= sat(i_cmd_yaw, -LAxisLim, LAxisLim);
      end
      r_p1_valid <= i_update_tick;
      if (i_update_tick) begin
        r_mode     <= w_mode_d;
        r_ramp_out <= w_ramp_d;
        for (int k = 0; k < 4; k++) r_clamp[k] <= sat(w_mix_m[k], LIdle, LMax);
      end
      r_motor_valid <= r_p1_valid;
      if (r_p1_valid) begin
        for (int k = 0; k < 4; k++) r_motor[k] <= w_motor_d[k];
      end
    end
  end

  assign o_mix_thr     = r_thr;
  assign o_mix_pitch   = r_pitch;
  assign o_mix_roll    = r_roll;
  assign o_mix_yaw     = r_yaw;
  assign o_motor_cmd1  = r_motor[0];
  assign o_motor_cmd2  = r_motor[1];
  assign o_motor_cmd3  = r_motor[2];
  assign o_motor_cmd4  = r_motor[3];
  assign o_motor_valid = r_motor_valid;
  assign o_state       = r_state;

endmodule

// File: tb/tb_motor_update_ctrl.sv
// Bench for motor_update_ctrl: directed + randomized steps against a rule-level reference model.
module tb_motor_update_ctrl;

  localparam int THR_LIM = 8191, AXIS_LIM = 8191, IDLE = 1200, MMAX = 16000;
  localparam int STEP = 100, ARM_THR = 200, STALE_MAX = 8, SLEW = 400;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, update_tick, arm_req, disarm_req, failsafe_in, motor_valid;
  logic signed [15:0] cmd_thr, cmd_pitch, cmd_roll, cmd_yaw;
  logic signed [15:0] mix_thr, mix_pitch, mix_roll, mix_yaw;
  logic signed [15:0] mix_m1, mix_m2, mix_m3, mix_m4;
  logic signed [15:0] motor_cmd1, motor_cmd2, motor_cmd3, motor_cmd4;
  logic [1:0] state;

  always #5 clk = ~clk;

  // Quad-X mixer stand-in.
  assign mix_m1 = mix_thr + mix_pitch + mix_roll - mix_yaw;
  assign mix_m2 = mix_thr + mix_pitch - mix_roll + mix_yaw;
  assign mix_m3 = mix_thr - mix_pitch - mix_roll - mix_yaw;
  assign mix_m4 = mix_thr - mix_pitch + mix_roll + mix_yaw;

  motor_update_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_thr(cmd_thr), .i_cmd_pitch(cmd_pitch), .i_cmd_roll(cmd_roll), .i_cmd_yaw(cmd_yaw),
    .i_update_tick(update_tick), .i_arm_req(arm_req), .i_disarm_req(disarm_req),
    .i_failsafe_in(failsafe_in), .o_mix_thr(mix_thr), .o_mix_pitch(mix_pitch),
    .o_mix_roll(mix_roll), .o_mix_yaw(mix_yaw), .i_mix_m1(mix_m1), .i_mix_m2(mix_m2),
    .i_mix_m3(mix_m3), .i_mix_m4(mix_m4), .o_motor_cmd1(motor_cmd1), .o_motor_cmd2(motor_cmd2),
    .o_motor_cmd3(motor_cmd3), .o_motor_cmd4(motor_cmd4), .o_motor_valid(motor_valid),
    .o_state(state)
  );

  int checks = 0, errors = 0;

  // Reference model: 0=DISARMED 1=ARMING 2=ARMED 3=FAILSAFE
  int m_state, m_ramp, m_stale, m_t, m_p, m_r, m_y;
  bit m_hold;
  int m_motor[4];
  int e_out[4];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ramp = 0; m_stale = 0; m_hold = 0;
    m_t = 0; m_p = 0; m_r = 0; m_y = 0;
    for (int k = 0; k < 4; k++) m_motor[k] = 0;
  endtask

  task automatic model_cycle(input bit tick, input bit xfer, input bit arm, input bit disarm,
                             input bit fs, input int t, input int p, input int r, input int y);
    int raw[4];
    int mode, nxt, prev;
    bit hit;
    mode = m_state;
    prev = m_state;
    if (tick) begin
      raw[0] = m_t + m_p + m_r - m_y;
      raw[1] = m_t + m_p - m_r + m_y;
      raw[2] = m_t - m_p - m_r - m_y;
      raw[3] = m_t - m_p + m_r + m_y;
      m_stale = m_hold ? 0 : ((m_stale < STALE_MAX) ? m_stale + 1 : STALE_MAX);
      if (m_state == 1) m_ramp = (m_ramp + STEP > IDLE) ? IDLE : m_ramp + STEP;
    end
    if (disarm) m_stale = 0;
    hit = (m_stale == STALE_MAX);
    nxt = m_state;
    if (disarm) nxt = 0;
    else if (m_state == 0 && arm && !fs && m_t <= ARM_THR) begin nxt = 1; m_ramp = 0; end
    else if ((m_state == 1 || m_state == 2) && (fs || hit)) nxt = 3;
    else if (m_state == 1 && m_ramp == IDLE) nxt = 2;
    m_state = nxt;
    if (tick) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = clampi(raw[k], IDLE, MMAX);
`ifdef MOTOR_UPDATE_CTRL_SLEW_LIMIT_EN
        c = m_motor[k] + clampi(c - m_motor[k], -SLEW, SLEW);
`endif
        if (m_state == 0 || m_state == 3 || prev == 0 || prev == 3) e_out[k] = 0;
        else if (mode == 1) e_out[k] = m_ramp;
        else e_out[k] = c;
        m_motor[k] = e_out[k];
      end
    end
    if (xfer) begin
      m_t = clampi(t, 0, THR_LIM);
      m_p = clampi(p, -AXIS_LIM, AXIS_LIM);
      m_r = clampi(r, -AXIS_LIM, AXIS_LIM);
      m_y = clampi(y, -AXIS_LIM, AXIS_LIM);
    end
    if (xfer) m_hold = 1;
    else if (tick) m_hold = 0;
  endtask

  task automatic clear_inputs();
    cmd_valid = 0; update_tick = 0; arm_req = 0; disarm_req = 0; failsafe_in = 0;
    cmd_thr = 0; cmd_pitch = 0; cmd_roll = 0; cmd_yaw = 0;
  endtask

  // One stimulus cycle; a tick additionally follows the output through its 2-cycle latency.
  task automatic cycle(input bit tick, input bit valid, input bit arm, input bit disarm,
                       input bit fs, input int t, input int p, input int r, input int y);
    cmd_valid = valid; update_tick = tick; arm_req = arm; disarm_req = disarm;
    failsafe_in = fs;
    cmd_thr = 16'(t); cmd_pitch = 16'(p); cmd_roll = 16'(r); cmd_yaw = 16'(y);
    chk("cmd_ready", cmd_ready, !m_hold);
    model_cycle(tick, valid && !m_hold, arm, disarm, fs, t, p, r, y);
    @(posedge clk); #1;
    clear_inputs();
    chk("state", state, m_state);
    chk("mix_thr", mix_thr, m_t);
    chk("mix_pitch", mix_pitch, m_p);
    if (tick) begin
      chk("valid_t1", motor_valid, 0);
      @(posedge clk); #1;
      chk("valid_t2", motor_valid, 1);
      chk("motor1", motor_cmd1, e_out[0]);
      chk("motor2", motor_cmd2, e_out[1]);
      chk("motor3", motor_cmd3, e_out[2]);
      chk("motor4", motor_cmd4, e_out[3]);
      @(posedge clk); #1;
      chk("valid_pulse", motor_valid, 0);
    end
  endtask

  task automatic cmd(input int t, input int p, input int r, input int y);
    cycle(0, 1, 0, 0, 0, t, p, r, y);
  endtask

  task automatic tick_only();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic arm_and_ramp(output int n);
    cmd(100, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("arming", state, 1);
    n = 0;
    while (state == 2'd1 && n < 20) begin
      cmd(100, 0, 0, 0);
      tick_only();
      n++;
      chk("ramp_step", motor_cmd1, (n * STEP > IDLE) ? IDLE : n * STEP);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int n;
    clear_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_valid", motor_valid, 0);
    chk("rst_motor1", motor_cmd1, 0);
    chk("rst_mix", mix_thr, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 0;
    @(posedge clk); #1;

    tick_only();
    chk("idle_motor", motor_cmd4, 0);

    cmd(500, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("arm_hi_thr", state, 0);
    tick_only();

    arm_and_ramp(n);
    chk("ramp_ticks", n, 12);
    chk("armed", state, 2);

    cmd(8000, 3000, 0, 0);
    tick_only();
`ifndef MOTOR_UPDATE_CTRL_SLEW_LIMIT_EN
    chk("mix_m1", motor_cmd1, 11000);
    chk("mix_m3", motor_cmd3, 5000);
`else
    chk("slew_m1", motor_cmd1, 1600);
`endif

    cmd(30000, 30000, 30000, 30000);
    tick_only();
    chk("thr_sat", mix_thr, THR_LIM);
    chk("yaw_sat", mix_yaw, AXIS_LIM);
`ifndef MOTOR_UPDATE_CTRL_SLEW_LIMIT_EN
    chk("m1_max", motor_cmd1, MMAX);
`endif

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) != 0 || m_stale >= 5) cmd(rnd16(), rnd16(), rnd16(), rnd16());
      if ($urandom_range(0, 3) == 0) cycle(1, 1, 0, 0, 0, rnd16(), rnd16(), rnd16(), rnd16());
      else tick_only();
    end
    chk("armed_after_rand", state, 2);

    // Transfer coinciding with a tick is held for the following tick.
    if (m_hold) tick_only();
    cycle(1, 1, 0, 0, 0, 4000, 0, 0, 0);
    chk("ready_low_coincide", cmd_ready, 0);
    tick_only();
    chk("coincide_used", motor_cmd2, 4000);

    for (int i = 0; i < STALE_MAX; i++) tick_only();
    chk("stale_failsafe", state, 3);
    chk("failsafe_zero", motor_cmd1, 0);
    cmd(100, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("fs_arm_ignored", state, 3);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("fs_disarm", state, 0);
    tick_only();

    cmd(100, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin cmd(100, 0, 0, 0); tick_only(); end
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("arming_fs", state, 3);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);

    arm_and_ramp(n);
    cmd(6000, 1000, -500, 250);
    tick_only();
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("disarm_beats_fs", state, 0);
    cmd(6000, 0, 0, 0);
    tick_only();
    chk("disarm_zero", motor_cmd3, 0);

    // Reset while a tick is in flight discards it.
    update_tick = 1;
    @(posedge clk); #1;
    update_tick = 0;
    rst = 1;
    #1;
    chk("rst_mid_state", state, 0);
    @(posedge clk); #1;
    chk("rst_mid_valid", motor_valid, 0);
    rst = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_mid_after", motor_valid, 0);
    chk("rst_mid_motor", motor_cmd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
